// File: rtl/sram_port_ctrl_pkg.sv
// Shared defaults and types for the single-port SRAM access controller.
package sram_port_ctrl_pkg;

    localparam int ADDR_W_DEF       = 12;
    localparam int DATA_W_DEF       = 137;
    localparam int RESP_DEPTH_DEF   = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    // One read response word as returned to the consumer.
    typedef logic [DATA_W_DEF-1:0] rd_resp_t;

    // Bits needed to hold any value in 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Small response holding FIFO with occupancy count; absorbs consumer back-pressure.
module sram_resp_fifo
    import sram_port_ctrl_pkg::*;
#(
    parameter int DEPTH = RESP_DEPTH_DEF,
    parameter int WIDTH = DATA_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [cnt_w(DEPTH)-1:0] count_o,
    output logic                    empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; a reset flushes the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // The read credit rule upstream makes overflow impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && count_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && count_q == '0));

endmodule

// File: rtl/sram_port_ctrl.sv
// Write/read arbiter with starvation guard in front of a single RW port SRAM,
// plus a flow-through read response path backed by a holding FIFO.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RESP_DEPTH   = RESP_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CW = cnt_w(RESP_DEPTH);
    localparam int SW = cnt_w(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic              wr_gnt, rd_gnt, rd_elig;
    logic              inflight_q, inflight_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty, fifo_push, fifo_pop;

    // A read may only issue if its response has a guaranteed FIFO slot.
    // Grants are held low while reset is asserted so the macro sees no enable.
    always_comb begin
        rd_elig = rd_req_valid &&
                  ((int'(fifo_count) + int'(inflight_q)) < RESP_DEPTH);
        wr_gnt  = 1'b0;
        rd_gnt  = 1'b0;
        if (reset_n) begin
            if (wr_req_valid && rd_elig) begin
                if (starve_q == STARVE_MAX) rd_gnt = 1'b1;
                else                        wr_gnt = 1'b1;
            end else if (wr_req_valid) begin
                wr_gnt = 1'b1;
            end else if (rd_elig) begin
                rd_gnt = 1'b1;
            end
        end
    end

    // Count consecutive arbitrations an eligible read lost to a write.
    always_comb begin
        starve_d   = starve_q;
        inflight_d = rd_gnt;
        if (rd_gnt)
            starve_d = '0;
        else if (rd_elig && wr_gnt && starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);
    end

    // Starvation counter and read-in-flight marker.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            inflight_q <= inflight_d;
        end
    end

    assign wr_req_ready = wr_gnt;
    assign rd_req_ready = rd_gnt;
    assign sram_en      = wr_gnt | rd_gnt;
    assign sram_wmode   = wr_gnt;
    // Idle cycles drive the write channel so the address bus stays quiet.
    assign sram_addr    = rd_gnt ? rd_req_addr : wr_req_addr;
    assign sram_wdata   = wr_req_data;

    // Fresh read data bypasses an empty FIFO; otherwise it queues behind the head.
    assign rd_resp_valid = !fifo_empty || inflight_q;
    assign rd_resp_data  = fifo_empty ? sram_rdata : fifo_head;
    assign fifo_pop      = !fifo_empty && rd_resp_ready;
    assign fifo_push     = inflight_q && (!fifo_empty || !rd_resp_ready);

    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (fifo_push),
        .data_i  (sram_rdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_sram_port_ctrl;
    import sram_port_ctrl_pkg::*;

    localparam int AW = 12;
    localparam int DW = 137;
    localparam logic [DW-1:0] ONE  = 1;
    localparam logic [DW-1:0] ZERO = 0;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid, rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sram_port_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .sram_en       (sram_en),
        .sram_wmode    (sram_wmode),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    // SRAM macro model: mem[a] starts as 0x1000 + a.
    logic [DW-1:0] mem [4096];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= sram_wdata;
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 unit after the edge; outputs are sampled mid-cycle.
    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
    endtask

    rd_resp_t exp_q[$];

    initial begin
        int next_addr;
        int got;
        for (int i = 0; i < 4096; i++) mem[i] = DW'(i) + DW'(32'h1000);
        wr_req_valid  = 1'b1;
        rd_req_valid  = 1'b1;
        wr_req_addr   = '0;
        wr_req_data   = '0;
        rd_req_addr   = '0;
        rd_resp_ready = 1'b1;

        // Reset: requests present but nothing may be granted.
        #3;
        check("rst_sram_en", DW'(sram_en), ZERO);
        check("rst_wr_ready", DW'(wr_req_ready), ZERO);
        check("rst_rd_ready", DW'(rd_req_ready), ZERO);
        check("rst_resp_valid", DW'(rd_resp_valid), ZERO);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle();

        // Write 0x5 then read it back.
        drive_edge();
        wr_req_valid = 1'b1; wr_req_addr = 12'h005; wr_req_data = 137'h1_2345;
        settle();
        check("t1_wr_ready", DW'(wr_req_ready), ONE);
        check("t1_wr_en", DW'({sram_en, sram_wmode}), DW'(2'b11));
        check("t1_wr_addr", DW'(sram_addr), DW'(12'h005));
        check("t1_wr_data", sram_wdata, 137'h1_2345);
        drive_edge();
        wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 12'h005;
        settle();
        check("t1_rd_ready", DW'(rd_req_ready), ONE);
        check("t1_rd_en", DW'({sram_en, sram_wmode}), DW'(2'b10));
        check("t1_rd_early", DW'(rd_resp_valid), ZERO);
        drive_edge();
        idle();
        settle();
        check("t1_resp_valid", DW'(rd_resp_valid), ONE);
        check("t1_resp_data", rd_resp_data, 137'h1_2345);
        check("t1_idle_en", DW'(sram_en), ZERO);

        // Back-to-back reads 0..3 with the consumer always ready.
        for (int i = 0; i <= 4; i++) begin
            drive_edge();
            rd_req_valid = (i < 4);
            rd_req_addr  = AW'(i);
            settle();
            if (i < 4) check("t2_rd_ready", DW'(rd_req_ready), ONE);
            if (i > 0) begin
                check("t2_resp_valid", DW'(rd_resp_valid), ONE);
                check("t2_resp_data", rd_resp_data, DW'(32'h1000 + i - 1));
            end
        end
        drive_edge();
        idle();
        settle();
        check("t2_drained", DW'(rd_resp_valid), ZERO);

        // Consumer stalled: only two reads may be outstanding.
        rd_resp_ready = 1'b0;
        drive_edge();
        rd_req_valid = 1'b1; rd_req_addr = 12'd10;
        settle();
        check("t3_g10", DW'(rd_req_ready), ONE);
        drive_edge();
        rd_req_addr = 12'd11;
        settle();
        check("t3_g11", DW'(rd_req_ready), ONE);
        check("t3_d10_ft", rd_resp_data, 137'h100A);
        drive_edge();
        rd_req_addr = 12'd12;
        settle();
        check("t3_block_a", DW'(rd_req_ready), ZERO);
        check("t3_head_a", rd_resp_data, 137'h100A);
        drive_edge();
        settle();
        check("t3_block_b", DW'(rd_req_ready), ZERO);
        drive_edge();
        rd_resp_ready = 1'b1;
        settle();
        check("t3_block_c", DW'(rd_req_ready), ZERO);
        check("t3_pop10", rd_resp_data, 137'h100A);
        drive_edge();
        settle();
        check("t3_g12", DW'(rd_req_ready), ONE);
        check("t3_pop11", rd_resp_data, 137'h100B);
        drive_edge();
        idle();
        settle();
        check("t3_d12", rd_resp_data, 137'h100C);
        check("t3_d12_valid", DW'(rd_resp_valid), ONE);

        // Starvation: writes win four times, then the read is forced through.
        drive_edge();
        wr_req_valid = 1'b1; wr_req_addr = 12'h020; wr_req_data = 137'hBEEF;
        rd_req_valid = 1'b1; rd_req_addr = 12'h030;
        settle();
        check("t4_pre_empty", DW'(rd_resp_valid), ZERO);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                drive_edge();
                settle();
            end
            check("t4_wr_ready", DW'(wr_req_ready), (k == 4) ? ZERO : ONE);
            check("t4_rd_ready", DW'(rd_req_ready), (k == 4) ? ONE : ZERO);
            if (k == 5) check("t4_resp", rd_resp_data, 137'h1030);
        end
        drive_edge();
        idle();
        settle();

        // Reset in the cycle after a read grant drops the in-flight read.
        drive_edge();
        rd_req_valid = 1'b1; rd_req_addr = 12'd1;
        settle();
        check("t5a_grant", DW'(rd_req_ready), ONE);
        drive_edge();
        idle();
        reset_n = 1'b0;
        settle();
        check("t5a_rst_valid", DW'(rd_resp_valid), ZERO);
        drive_edge();
        reset_n = 1'b1;
        settle();
        check("t5a_post_valid", DW'(rd_resp_valid), ZERO);
        drive_edge();
        settle();
        check("t5a_post_valid2", DW'(rd_resp_valid), ZERO);

        // Reset flushes a queued response and clears a partly-built starve count.
        rd_resp_ready = 1'b0;
        drive_edge();
        rd_req_valid = 1'b1; rd_req_addr = 12'd2;
        settle();
        check("t5b_grant", DW'(rd_req_ready), ONE);
        drive_edge();
        wr_req_valid = 1'b1; wr_req_addr = 12'h021; rd_req_addr = 12'd3;
        settle();
        check("t5b_d2", rd_resp_data, 137'h1002);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                drive_edge();
                settle();
            end
            check("t5b_wr_win", DW'(wr_req_ready), ONE);
        end
        drive_edge();
        reset_n = 1'b0;
        settle();
        check("t5b_flushed", DW'(rd_resp_valid), ZERO);
        check("t5b_rst_wr", DW'(wr_req_ready), ZERO);
        drive_edge();
        reset_n = 1'b1;
        rd_resp_ready = 1'b1;
        settle();
        check("t5b_after_valid", DW'(rd_resp_valid), ZERO);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                drive_edge();
                settle();
            end
            check("t5b_rd_ready", DW'(rd_req_ready), (k == 4) ? ONE : ZERO);
        end
        drive_edge();
        idle();
        settle();
        check("t5b_d3", rd_resp_data, 137'h1003);

        // Streaming reads with a one-cycle consumer stall; order must hold.
        next_addr = 'h40;
        got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            drive_edge();
            rd_req_valid  = (next_addr < 'h48);
            rd_req_addr   = AW'(next_addr);
            rd_resp_ready = (c != 3);
            settle();
            if (rd_resp_valid && rd_resp_ready) begin
                check("t6_expected", DW'(exp_q.size() != 0), ONE);
                if (exp_q.size() != 0) begin
                    check("t6_data", rd_resp_data, exp_q.pop_front());
                    got++;
                end
            end
            if (rd_req_valid && rd_req_ready) begin
                exp_q.push_back(DW'(32'h1000 + next_addr));
                next_addr++;
            end
        end
        check("t6_count", DW'(got), DW'(8));
        drive_edge();
        idle();
        rd_resp_ready = 1'b1;
        settle();
        check("t6_no_dup", DW'(rd_resp_valid), ZERO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
